// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, protocol byte codes, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StLineAck,
        StWaitResp,
        StDone
    } ps2_state_e;

    // Device response codes
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // Scan-code prefixes used by the receiver
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;

    // Parity bit that makes the total count of ones (data + parity) odd
    function automatic logic odd_parity(input logic [7:0] i_data);
        return ~(^i_data);
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one raw PS/2 line with falling-edge detect.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module ps2_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise the asynchronous line and keep one cycle of history
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-device PS/2 command sender: inhibit, request-to-send, clock out one or two bytes,
// check the line ACK and the device response, retrying each byte a bounded number of times.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 2000,
    parameter int unsigned TIMEOUT_CYC = 400000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_byte,
    input  logic       i_cmd_has_arg,
    input  logic [7:0] i_cmd_arg,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_rx_inhibit,
    output logic       o_done,
    output logic       o_ok
);

    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYC - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    ps2_state_e  r_state, w_state_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [7:0]  r_arg, w_arg_nxt;
    logic        r_has_arg, w_has_arg_nxt;
    logic        r_sel_arg, w_sel_arg_nxt;
    logic [7:0]  r_retry, w_retry_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_edge, w_edge_nxt;
    logic        r_ok, w_ok_nxt;

    logic        w_clk_fall;
    logic        w_clk_sync;
    logic        w_data_sync;
    logic        w_data_fall;
    logic        w_unused;
    logic [7:0]  w_cur;
    logic [2:0]  w_bit_idx;
    logic [7:0]  w_retry_inc;
    logic        w_tmo;
    logic        w_fail;

    ps2_sync u_clk_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .i_line  (i_ps2_clk_in),
        .o_sync  (w_clk_sync),
        .o_fall  (w_clk_fall)
    );

    ps2_sync u_data_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .i_line  (i_ps2_data_in),
        .o_sync  (w_data_sync),
        .o_fall  (w_data_fall)
    );

    assign w_unused    = w_clk_sync ^ w_data_fall;
    assign w_cur       = r_sel_arg ? r_arg : r_cmd;
    assign w_bit_idx   = 3'(r_edge - 4'd1);
    assign w_retry_inc = r_retry + 8'd1;
    assign w_tmo       = (r_cnt == TMO_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state   <= StIdle;
            r_cmd     <= 8'h00;
            r_arg     <= 8'h00;
            r_has_arg <= 1'b0;
            r_sel_arg <= 1'b0;
            r_retry   <= 8'h00;
            r_cnt     <= 32'h0;
            r_edge    <= 4'h0;
            r_ok      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_arg     <= w_arg_nxt;
            r_has_arg <= w_has_arg_nxt;
            r_sel_arg <= w_sel_arg_nxt;
            r_retry   <= w_retry_nxt;
            r_cnt     <= w_cnt_nxt;
            r_edge    <= w_edge_nxt;
            r_ok      <= w_ok_nxt;
        end
    end

    // Next-state logic and line drivers
    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_arg_nxt     = r_arg;
        w_has_arg_nxt = r_has_arg;
        w_sel_arg_nxt = r_sel_arg;
        w_retry_nxt   = r_retry;
        w_cnt_nxt     = r_cnt;
        w_edge_nxt    = r_edge;
        w_ok_nxt      = r_ok;
        w_fail        = 1'b0;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_data_oe = 1'b0;
        o_cmd_ready   = 1'b0;
        o_done        = 1'b0;

        unique case (r_state)
            StIdle: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_cmd_nxt     = i_cmd_byte;
                    w_arg_nxt     = i_cmd_arg;
                    w_has_arg_nxt = i_cmd_has_arg;
                    w_sel_arg_nxt = 1'b0;
                    w_retry_nxt   = 8'h00;
                    w_cnt_nxt     = 32'h0;
                    w_state_nxt   = StInhibit;
                end
            end
            StInhibit: begin
                o_ps2_clk_oe = 1'b1;
                if (r_cnt == INH_LAST) begin
                    w_state_nxt = StRts;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            StRts: begin
                o_ps2_clk_oe  = 1'b1;
                o_ps2_data_oe = 1'b1;
                w_edge_nxt    = 4'h0;
                w_cnt_nxt     = 32'h0;
                w_state_nxt   = StShift;
            end
            StShift: begin
                // Edge 0 = start bit, 1..8 = data LSB first, 9 = parity
                if (r_edge == 4'd0) begin
                    o_ps2_data_oe = 1'b1;
                end else if (r_edge <= 4'd8) begin
                    o_ps2_data_oe = ~w_cur[w_bit_idx];
                end else begin
                    o_ps2_data_oe = ~odd_parity(w_cur);
                end
                w_cnt_nxt = r_cnt + 32'd1;
                if (w_tmo) begin
                    o_ps2_data_oe = 1'b0;
                    w_fail        = 1'b1;
                end else if (w_clk_fall) begin
                    w_edge_nxt = r_edge + 4'd1;
                    if (r_edge == 4'd9) begin
                        w_state_nxt = StLineAck;
                    end
                end
            end
            StLineAck: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (w_tmo) begin
                    w_fail = 1'b1;
                end else if (w_clk_fall) begin
                    if (!w_data_sync) begin
                        w_cnt_nxt   = 32'h0;
                        w_state_nxt = StWaitResp;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            StWaitResp: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (i_rx_valid) begin
                    if (i_rx_byte == PS2_ACK) begin
                        if (!r_sel_arg && r_has_arg) begin
                            w_sel_arg_nxt = 1'b1;
                            w_retry_nxt   = 8'h00;
                            w_cnt_nxt     = 32'h0;
                            w_state_nxt   = StInhibit;
                        end else begin
                            w_ok_nxt    = 1'b1;
                            w_state_nxt = StDone;
                        end
                    end else begin
                        // RESEND and unexpected bytes both retry the same byte
                        w_fail = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_fail = 1'b1;
                end
            end
            StDone: begin
                o_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (w_fail) begin
            if ({24'h0, w_retry_inc} < MAX_RETRY) begin
                w_retry_nxt = w_retry_inc;
                w_cnt_nxt   = 32'h0;
                w_state_nxt = StInhibit;
            end else begin
                w_ok_nxt    = 1'b0;
                w_state_nxt = StDone;
            end
        end
    end

    assign o_rx_inhibit = (r_state != StIdle);
    assign o_ok         = (r_state == StDone) & r_ok;

endmodule
